arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter NUM_IN, default 4, number of input channels, legal 2..16.
REQ-002 Parameter DATA_W, default 64, payload width in bits, legal 8..512.
REQ-003 Parameter ARB_RR, default 1; 1 = round-robin arbitration, 0 = fixed priority with lowest index winning.
REQ-004 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port in_data, input, NUM_IN*DATA_W, flattened payloads; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-007 Port in_valid, input, NUM_IN, per-channel beat valid.
REQ-008 Port in_last, input, NUM_IN, per-channel end-of-packet marker.
REQ-009 Port in_ready, output, NUM_IN, per-channel beat accept.
REQ-010 Port out_data, output, DATA_W, registered payload.
REQ-011 Port out_valid, output, 1, registered beat valid.
REQ-012 Port out_last, output, 1, registered end-of-packet marker.
REQ-013 Port out_sel, output, clog2(NUM_IN), source channel of the current output beat.
REQ-014 Port out_ready, input, 1, downstream accept.

Function
REQ-015 A beat SHALL transfer on any edge where valid and ready are both high; the input side and the output side are independent.
REQ-016 The output register SHALL load when out_valid is low or out_ready is high (load_en), so throughput is one beat per cycle.
REQ-017 Latency SHALL be one cycle: a beat accepted at edge N appears on out_* immediately after edge N.
REQ-018 out_* SHALL hold stable while out_valid is high and out_ready is low.
REQ-019 The FSM SHALL have states IDLE and LOCKED.
REQ-020 In IDLE with load_en high, the arbiter SHALL grant combinationally among asserted in_valid bits, and that channel's in_ready SHALL be high in the same cycle.
REQ-021 In IDLE, a granted beat with in_last low SHALL move the FSM to LOCKED and store the grant; a granted beat with in_last high SHALL keep the FSM in IDLE.
REQ-022 In LOCKED, only the stored channel SHALL see in_ready, and only while load_en is high; all other in_ready bits SHALL be low.
REQ-023 In LOCKED, acceptance of a beat with in_last high SHALL return the FSM to IDLE.
REQ-024 Packets SHALL never interleave on the output.
REQ-025 When ARB_RR is 1, the priority pointer SHALL update to grant+1 (mod NUM_IN) only on acceptance of a last beat; the search SHALL start at the pointer and wrap from NUM_IN-1 to 0.
REQ-026 When ARB_RR is 0, the pointer SHALL be unused and held at 0.
REQ-027 If no input is valid, or load_en is low, the FSM, the pointer and all in_ready bits SHALL remain unchanged/low as applicable.
REQ-028 A channel dropping in_valid mid-packet SHALL keep the lock; the block SHALL wait and not re-arbitrate.

Reset
REQ-029 Asserting rst_n low SHALL immediately force out_valid=0, out_last=0, out_data=0, out_sel=0, FSM=IDLE, pointer=0 and in_ready=0, including mid-packet; any partial packet is dropped from the block's state.
REQ-030 Deassertion SHALL be synchronised externally; the first arbitration happens on the first edge after release.

Configuration
REQ-031 Macro ARB_MUX_FORCE_EN, when defined, SHALL add inputs force_en (1 bit) and force_sel (clog2(NUM_IN) bits).
REQ-032 With ARB_MUX_FORCE_EN defined and force_en high in IDLE, the grant SHALL be force_sel regardless of priority, and the pointer SHALL not update.
REQ-033 Without ARB_MUX_FORCE_EN, these ports SHALL be absent and arbitration SHALL be per REQ-020..026.

Structure
REQ-034 Package arb_mux_pkg SHALL hold the FSM state typedef (IDLE, LOCKED) and the NUM_IN/DATA_W legal-range constants.
REQ-035 Sub-module rr_arbiter SHALL contain the pointer-rotated priority encoder, taking request, pointer and mode and returning a one-hot grant plus index.

Verification
REQ-036 Channels 0..3 each send a 1-beat packet simultaneously with ARB_RR=1 and out_ready=1 -> out_sel sequence is 0,1,2,3 on consecutive cycles.
REQ-037 Channel 2 sends 3 beats 0xA0..0xA2 while channel 0 is valid -> output is 0xA0,0xA1,0xA2 from channel 2, then channel 0; no interleave.
REQ-038 out_ready is held low for 5 cycles with out_valid high -> out_data and out_sel are stable and all in_ready bits are 0.
REQ-039 ARB_RR=0 with channels 1 and 3 continuously valid -> channel 1 is always granted.
REQ-040 rst_n is pulsed low mid-packet on channel 1 -> outputs are 0 immediately and the next grant is chosen fresh from IDLE with pointer 0.
REQ-041 ARB_MUX_FORCE_EN defined, force_en=1, force_sel=3, all channels valid -> only channel 3 is granted, and the pointer is unchanged.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared types and legal-range constants for the arb_mux packet arbiter/multiplexer.
package arb_mux_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 16;
  localparam int DATA_W_MIN = 8;
  localparam int DATA_W_MAX = 512;

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Pointer-rotated priority encoder: searches i_req starting at i_ptr (or at 0 in
// fixed-priority mode), wrapping from NUM_IN-1 to 0; returns one-hot grant and index.
module rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  input  logic              i_rr,
  output logic [NUM_IN-1:0] o_grant,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any
);

  always_comb begin
    int   base;
    int   k;
    logic found;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    base    = i_rr ? int'(i_ptr) : 0;
    if (base >= NUM_IN) base = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      k = base + i;
      if (k >= NUM_IN) k = k - NUM_IN;
      if (!found && i_req[k]) begin
        found      = 1'b1;
        o_grant[k] = 1'b1;
        o_idx      = IDX_W'(k);
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/arb_mux.sv
// Packet-aware N:1 arbiter/mux with a one-beat output register; a granted packet
// holds the lock until its last beat. Optional macro ARB_MUX_FORCE_EN adds force_en/force_sel.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 64,
  parameter int ARB_RR = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  input  logic [NUM_IN-1:0]          in_valid,
  input  logic [NUM_IN-1:0]          in_last,
  output logic [NUM_IN-1:0]          in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  output logic                       out_last,
  output logic [$clog2(NUM_IN)-1:0]  out_sel,
  input  logic                       out_ready,
`ifdef ARB_MUX_FORCE_EN
  input  logic                       force_en,
  input  logic [$clog2(NUM_IN)-1:0]  force_sel,
`endif
  output state_e                     dbg_state,
  output logic [$clog2(NUM_IN)-1:0]  dbg_ptr
);

  localparam int IDX_W = $clog2(NUM_IN);

  // Handshake: a beat moves on a rising edge where valid and ready are both high.
  // Input and output sides are independent; in_ready never depends on out_valid alone
  // but on load_en, so the output register refills in the same cycle it drains.

  state_e             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_lock;
  logic               r_lock_forced;

  logic               w_load_en;
  logic               w_force;
  logic [IDX_W-1:0]   w_force_sel;
  logic [NUM_IN-1:0]  w_arb_grant;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_any;
  logic [IDX_W-1:0]   w_sel;
  logic [NUM_IN-1:0]  w_onehot;
  logic [NUM_IN-1:0]  w_grant;
  logic               w_acc;
  logic               w_beat_last;
  logic [DATA_W-1:0]  w_beat_data;
  logic               w_pkt_forced;
  logic [IDX_W-1:0]   w_ptr_next;

`ifdef ARB_MUX_FORCE_EN
  assign w_force     = force_en;
  assign w_force_sel = force_sel;
`else
  assign w_force     = 1'b0;
  assign w_force_sel = '0;
`endif

  assign w_load_en = !out_valid || out_ready;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_arb (
    .i_req   (in_valid),
    .i_ptr   (r_ptr),
    .i_rr    (ARB_RR != 0),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  always_comb begin
    w_sel = w_arb_idx;
    if (r_state == ST_LOCKED) w_sel = r_lock;
    else if (w_force)         w_sel = w_force_sel;
  end

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_IN; i++) w_onehot[i] = (IDX_W'(i) == w_sel);
  end

  // The locked channel keeps ready even while its valid is low, so a stalled
  // source resumes its packet without re-arbitration.
  always_comb begin
    w_grant = '0;
    if (r_state == ST_LOCKED)  w_grant = w_onehot;
    else if (w_force)          w_grant = w_onehot & in_valid;
    else if (w_arb_any)        w_grant = w_arb_grant;
    in_ready = (w_load_en && rst_n) ? w_grant : '0;
  end

  always_comb begin
    w_beat_data = '0;
    w_beat_last = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (IDX_W'(i) == w_sel) begin
        w_beat_data = in_data[i*DATA_W +: DATA_W];
        w_beat_last = in_last[i];
      end
    end
  end

  assign w_acc        = |(in_ready & in_valid);
  assign w_pkt_forced = (r_state == ST_LOCKED) ? r_lock_forced : w_force;
  assign w_ptr_next   = (w_sel == IDX_W'(NUM_IN - 1)) ? '0 : w_sel + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_data      <= '0;
      out_sel       <= '0;
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_lock        <= '0;
      r_lock_forced <= 1'b0;
    end else begin
      if (w_load_en) begin
        out_valid <= w_acc;
        if (w_acc) begin
          out_data <= w_beat_data;
          out_last <= w_beat_last;
          out_sel  <= w_sel;
        end
      end
      if (w_acc) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_beat_last) begin
              r_state       <= ST_LOCKED;
              r_lock        <= w_sel;
              r_lock_forced <= w_force;
            end
          end
          ST_LOCKED: begin
            if (w_beat_last) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
        // Rotate only at packet boundaries; forced packets leave fairness untouched.
        if ((ARB_RR != 0) && w_beat_last && !w_pkt_forced) r_ptr <= w_ptr_next;
      end
    end
  end

  assign dbg_state = r_state;
  assign dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: round-robin instance driven by per-channel beat sources with a
// scoreboard, plus a fixed-priority instance exercised from a vector table.
module tb_arb_mux;
  import arb_mux_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;
  localparam int EW = IW + 1 + W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // round-robin instance
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_last = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_last;
  logic [IW-1:0]  out_sel;
  logic           out_ready = 1'b1;
  state_e         dbg_state;
  logic [IW-1:0]  dbg_ptr;
`ifdef ARB_MUX_FORCE_EN
  logic           force_en = 1'b0;
  logic [IW-1:0]  force_sel = '0;
  logic           fp_force_en = 1'b0;
  logic [IW-1:0]  fp_force_sel = '0;
`endif

  // fixed-priority instance
  logic [N*W-1:0] fp_in_data = '0;
  logic [N-1:0]   fp_in_valid = '0;
  logic [N-1:0]   fp_in_last = '1;
  logic [N-1:0]   fp_in_ready;
  logic [W-1:0]   fp_out_data;
  logic           fp_out_valid;
  logic           fp_out_last;
  logic [IW-1:0]  fp_out_sel;
  logic           fp_out_ready = 1'b1;
  state_e         fp_dbg_state;
  logic [IW-1:0]  fp_dbg_ptr;

  arb_mux #(.NUM_IN(N), .DATA_W(W), .ARB_RR(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready),
`ifdef ARB_MUX_FORCE_EN
    .force_en(force_en), .force_sel(force_sel),
`endif
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  arb_mux #(.NUM_IN(N), .DATA_W(W), .ARB_RR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_data(fp_in_data), .in_valid(fp_in_valid),
    .in_last(fp_in_last), .in_ready(fp_in_ready), .out_data(fp_out_data),
    .out_valid(fp_out_valid), .out_last(fp_out_last), .out_sel(fp_out_sel),
    .out_ready(fp_out_ready),
`ifdef ARB_MUX_FORCE_EN
    .force_en(fp_force_en), .force_sel(fp_force_sel),
`endif
    .dbg_state(fp_dbg_state), .dbg_ptr(fp_dbg_ptr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // scoreboard: {sel, last, data} in expected output order
  logic [EW-1:0] exp_q[$];

  task automatic push_exp(input logic [IW-1:0] s, input logic l, input logic [W-1:0] d);
    exp_q.push_back({s, l, d});
  endtask

  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got sel=%0d last=%0b data=%0h, expected no beat",
                 out_sel, out_last, out_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_beat", 64'({out_sel, out_last, out_data}), 64'(e));
      end
    end
  end

  // per-channel beat sources
  logic [W-1:0] b_data [N][8];
  logic         b_last [N][8];
  int           b_cnt  [N];
  int           b_pos  [N];
  logic [N-1:0] hold_mask = '0;

  logic [N-1:0] snap_in_ready;
  logic         snap_out_valid;
  logic [W-1:0] snap_out_data;
  logic [IW-1:0] snap_out_sel;

  task automatic apply_drive();
    for (int i = 0; i < N; i++) begin
      if (b_pos[i] < b_cnt[i]) begin
        in_valid[i]      = !hold_mask[i];
        in_data[i*W +: W] = b_data[i][b_pos[i]];
        in_last[i]       = b_last[i][b_pos[i]];
      end else begin
        in_valid[i]      = 1'b0;
        in_data[i*W +: W] = '0;
        in_last[i]       = 1'b0;
      end
    end
  endtask

  task automatic clear_chans();
    for (int i = 0; i < N; i++) begin
      b_cnt[i] = 0;
      b_pos[i] = 0;
    end
    apply_drive();
  endtask

  task automatic add_beat(input int ch, input logic [W-1:0] d, input logic l);
    b_data[ch][b_cnt[ch]] = d;
    b_last[ch][b_cnt[ch]] = l;
    b_cnt[ch]++;
  endtask

  // one clock: drive, snapshot at negedge, advance sources past the edge
  task automatic step();
    logic [N-1:0] acc;
    apply_drive();
    @(negedge clk);
    acc            = in_valid & in_ready;
    snap_in_ready  = in_ready;
    snap_out_valid = out_valid;
    snap_out_data  = out_data;
    snap_out_sel   = out_sel;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) b_pos[i]++;
    apply_drive();
  endtask

  typedef struct {
    logic [N-1:0]  valid;
    logic [N-1:0]  exp_ready;
    logic [IW-1:0] exp_sel;
  } fp_vec_t;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    fp_vec_t      fp_tab[7];
    logic [W-1:0] rnd[N];
    logic [W-1:0] fp_vals[N];
    logic [N-1:0] rr_ready_seq[5];

    clear_chans();
    // reset: outputs idle even with every channel requesting
    for (int i = 0; i < N; i++) begin
      rnd[i] = W'($urandom_range(0, 16'hFFFF));
      add_beat(i, rnd[i], 1'b1);
    end
    apply_drive();
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_sel",   64'(out_sel),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_state",     64'(dbg_state), 64'(ST_IDLE));
    check("rst_ptr",       64'(dbg_ptr),   64'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // four simultaneous single-beat packets come out 0,1,2,3 back to back
    for (int i = 0; i < N; i++) push_exp(IW'(i), 1'b1, rnd[i]);
    rr_ready_seq[0] = 4'b0001;
    rr_ready_seq[1] = 4'b0010;
    rr_ready_seq[2] = 4'b0100;
    rr_ready_seq[3] = 4'b1000;
    rr_ready_seq[4] = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      step();
      check("rr_in_ready", 64'(snap_in_ready), 64'(rr_ready_seq[c]));
    end
    check("rr_q_empty", 64'(exp_q.size()), 64'd0);
    check("rr_ptr_wrap", 64'(dbg_ptr), 64'd0);

    // channel 2 packet locks out channel 0 until its last beat
    clear_chans();
    add_beat(2, 16'h00A0, 1'b0);
    add_beat(2, 16'h00A1, 1'b0);
    add_beat(2, 16'h00A2, 1'b1);
    push_exp(2'd2, 1'b0, 16'h00A0);
    push_exp(2'd2, 1'b0, 16'h00A1);
    push_exp(2'd2, 1'b1, 16'h00A2);
    push_exp(2'd0, 1'b1, 16'h0005);
    step();
    check("lock_first_ready", 64'(snap_in_ready), 64'b0100);
    check("lock_state", 64'(dbg_state), 64'(ST_LOCKED));
    add_beat(0, 16'h0005, 1'b1);
    step();
    check("lock_mid_ready", 64'(snap_in_ready), 64'b0100);
    step();
    check("lock_last_ready", 64'(snap_in_ready), 64'b0100);
    step();
    check("after_lock_ready", 64'(snap_in_ready), 64'b0001);
    step();
    check("lock_q_empty", 64'(exp_q.size()), 64'd0);
    check("lock_ptr", 64'(dbg_ptr), 64'd1);

    // downstream stall: output holds, no input accepted
    clear_chans();
    add_beat(1, 16'h00B0, 1'b0);
    add_beat(1, 16'h00B1, 1'b1);
    add_beat(3, 16'h00C0, 1'b1);
    push_exp(2'd1, 1'b0, 16'h00B0);
    push_exp(2'd1, 1'b1, 16'h00B1);
    push_exp(2'd3, 1'b1, 16'h00C0);
    step();
    check("stall_pre_ready", 64'(snap_in_ready), 64'b0010);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("stall_in_ready",  64'(snap_in_ready),  64'd0);
      check("stall_out_valid", 64'(snap_out_valid), 64'd1);
      check("stall_out_data",  64'(snap_out_data),  64'h00B0);
      check("stall_out_sel",   64'(snap_out_sel),   64'd1);
    end
    out_ready = 1'b1;
    step();
    check("stall_resume_ready", 64'(snap_in_ready), 64'b0010);
    step();
    check("stall_next_ready", 64'(snap_in_ready), 64'b1000);
    step();
    check("stall_q_empty", 64'(exp_q.size()), 64'd0);
    check("stall_ptr", 64'(dbg_ptr), 64'd0);

    // source drops valid mid-packet: lock kept, no re-arbitration
    clear_chans();
    add_beat(0, 16'h00D0, 1'b0);
    add_beat(0, 16'h00D1, 1'b1);
    add_beat(2, 16'h00E0, 1'b1);
    push_exp(2'd0, 1'b0, 16'h00D0);
    push_exp(2'd0, 1'b1, 16'h00D1);
    push_exp(2'd2, 1'b1, 16'h00E0);
    step();
    hold_mask = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      step();
      check("gap_in_ready", 64'(snap_in_ready), 64'b0001);
      check("gap_state", 64'(dbg_state), 64'(ST_LOCKED));
    end
    hold_mask = '0;
    step();
    step();
    check("gap_next_ready", 64'(snap_in_ready), 64'b0100);
    step();
    check("gap_q_empty", 64'(exp_q.size()), 64'd0);
    check("gap_ptr", 64'(dbg_ptr), 64'd3);

    // reset mid-packet on channel 1
    clear_chans();
    add_beat(1, 16'h00F0, 1'b0);
    add_beat(1, 16'h00F1, 1'b0);
    add_beat(1, 16'h00F2, 1'b1);
    push_exp(2'd1, 1'b0, 16'h00F0);
    step();
    check("pre_rst_state", 64'(dbg_state), 64'(ST_LOCKED));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data",  64'(out_data),  64'd0);
    check("mid_rst_out_last",  64'(out_last),  64'd0);
    check("mid_rst_out_sel",   64'(out_sel),   64'd0);
    check("mid_rst_in_ready",  64'(in_ready),  64'd0);
    check("mid_rst_state",     64'(dbg_state), 64'(ST_IDLE));
    check("mid_rst_ptr",       64'(dbg_ptr),   64'd0);
    clear_chans();
    add_beat(1, 16'h0111, 1'b1);
    add_beat(2, 16'h0222, 1'b1);
    add_beat(3, 16'h0333, 1'b1);
    push_exp(2'd1, 1'b1, 16'h0111);
    push_exp(2'd2, 1'b1, 16'h0222);
    push_exp(2'd3, 1'b1, 16'h0333);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 64'(snap_in_ready), 64'b0010);
    step();
    step();
    step();
    check("post_rst_q_empty", 64'(exp_q.size()), 64'd0);
    check("post_rst_ptr", 64'(dbg_ptr), 64'd0);

`ifdef ARB_MUX_FORCE_EN
    // forced grant to channel 3 with everyone requesting; pointer stays put
    clear_chans();
    for (int i = 0; i < 3; i++) add_beat(i, W'(16'h0400 + i), 1'b1);
    for (int i = 0; i < 3; i++) begin
      add_beat(3, W'(16'h0430 + i), 1'b1);
      push_exp(2'd3, 1'b1, W'(16'h0430 + i));
    end
    force_en  = 1'b1;
    force_sel = 2'd3;
    for (int c = 0; c < 3; c++) begin
      step();
      check("force_in_ready", 64'(snap_in_ready), 64'b1000);
    end
    step();
    check("force_idle_ready", 64'(snap_in_ready), 64'd0);
    check("force_ptr", 64'(dbg_ptr), 64'd0);
    check("force_q_empty", 64'(exp_q.size()), 64'd0);
    force_en = 1'b0;
    clear_chans();
    step();
`endif

    // drain bound for anything still outstanding
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    check("final_q_empty", 64'(exp_q.size()), 64'd0);

    // fixed-priority instance: lowest valid index always wins
    fp_tab[0] = '{valid: 4'b1010, exp_ready: 4'b0010, exp_sel: 2'd1};
    fp_tab[1] = '{valid: 4'b1000, exp_ready: 4'b1000, exp_sel: 2'd3};
    fp_tab[2] = '{valid: 4'b0000, exp_ready: 4'b0000, exp_sel: 2'd0};
    fp_tab[3] = '{valid: 4'b1111, exp_ready: 4'b0001, exp_sel: 2'd0};
    fp_tab[4] = '{valid: 4'b0110, exp_ready: 4'b0010, exp_sel: 2'd1};
    fp_tab[5] = '{valid: 4'b1100, exp_ready: 4'b0100, exp_sel: 2'd2};
    fp_tab[6] = '{valid: 4'b1001, exp_ready: 4'b0001, exp_sel: 2'd0};
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < N; i++) begin
        fp_vals[i] = W'($urandom_range(0, 16'hFFFF));
        fp_in_data[i*W +: W] = fp_vals[i];
      end
      fp_in_valid = fp_tab[t].valid;
      @(negedge clk);
      check("fp_in_ready", 64'(fp_in_ready), 64'(fp_tab[t].exp_ready));
      @(posedge clk);
      #1;
      fp_in_valid = '0;
      check("fp_out_valid", 64'(fp_out_valid), 64'(|fp_tab[t].valid));
      if (|fp_tab[t].valid) begin
        check("fp_out_sel",  64'(fp_out_sel),  64'(fp_tab[t].exp_sel));
        check("fp_out_data", 64'(fp_out_data), 64'(fp_vals[fp_tab[t].exp_sel]));
      end
    end

    // channels 1 and 3 continuously valid: channel 1 every time
    fp_in_valid = 4'b1010;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("fp_hold_ready", 64'(fp_in_ready), 64'b0010);
      @(posedge clk);
      #1;
      check("fp_hold_sel", 64'(fp_out_sel), 64'd1);
    end
    fp_in_valid = '0;
    check("fp_ptr_zero", 64'(fp_dbg_ptr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
